// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and sizing for the ID-stage issue controller
package pipe_ctrl_pkg;

  // Outstanding writes per register: one each in ID/EX, EX/MEM and MEM/WB.
  localparam int MAX_INFLIGHT = 3;
  // Per-register counter width; 2**CNT_W must exceed MAX_INFLIGHT.
  localparam int CNT_W        = 2;
  localparam int NUM_REGS     = 32;
  localparam int IDX_W        = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } sched_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write counters with two pending read ports
module reg_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc_en,
  input  logic [IDX_W-1:0] i_inc_idx,
  input  logic             i_dec_en,
  input  logic [IDX_W-1:0] i_dec_idx,
  input  logic [IDX_W-1:0] i_ra_idx,
  input  logic [IDX_W-1:0] i_rb_idx,
  output logic             o_ra_pending,
  output logic             o_rb_pending,
  output logic             o_any_pending
);

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc_hit;
  logic [NUM_REGS-1:0] w_dec_hit;
  logic [NUM_REGS-1:0] w_up;
  logic [NUM_REGS-1:0] w_dn;
  logic [NUM_REGS-1:0] w_at_max;
  logic [NUM_REGS-1:0] w_nonzero;

  // Decode increment/decrement targets; x0 is never tracked.
  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    w_at_max  = '0;
    w_nonzero = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc_hit[i] = i_inc_en && (i_inc_idx == IDX_W'(i));
      w_dec_hit[i] = i_dec_en && (i_dec_idx == IDX_W'(i));
      w_at_max[i]  = (r_cnt[i] == CNT_W'(MAX_INFLIGHT));
      w_nonzero[i] = (r_cnt[i] != '0);
    end
  end

  // Issue and retire of the same register cancel each other out.
  assign w_up = w_inc_hit & ~w_dec_hit;
  assign w_dn = w_dec_hit & ~w_inc_hit;

  // Saturating counter update; overflow and underflow are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_up[i] && !w_at_max[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dn[i] && w_nonzero[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign o_ra_pending  = (i_ra_idx != '0) && w_nonzero[i_ra_idx];
  assign o_rb_pending  = (i_rb_idx != '0) && w_nonzero[i_rb_idx];
  assign o_any_pending = |w_nonzero;

  // A write issued beyond MAX_INFLIGHT or a retire with nothing in flight is a pipeline bug.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    ((w_up & w_at_max) == '0));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    ((w_dn & ~w_nonzero) == '0));

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - ID-stage issue controller: RAW stall, MUL sequencing, branch flush
module hazard_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_inst,
  input  logic             id_uses_ra,
  input  logic             id_uses_rb,
  input  logic [IDX_W-1:0] id_ra_idx,
  input  logic [IDX_W-1:0] id_rb_idx,
  input  logic             id_reg_wr,
  input  logic [IDX_W-1:0] id_dest_reg_idx,
  input  logic             id_is_mul,
  input  logic             ex_take_branch,
  input  logic             wb_valid_inst,
  input  logic             wb_reg_wr,
  input  logic [IDX_W-1:0] wb_dest_reg_idx,
  output logic             stall,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             ex_mem_bubble,
  output logic             pending_any
);

  localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [MUL_W-1:0] r_mul_cnt;
  logic [MUL_W-1:0] w_mul_cnt_nxt;

  logic w_ra_pending;
  logic w_rb_pending;
  logic w_hazard;
  logic w_issue;
  logic w_inc_en;
  logic w_dec_en;

  assign w_hazard = id_valid_inst &
                    ((id_uses_ra & w_ra_pending) | (id_uses_rb & w_rb_pending));

  // Only issued writers are counted; a squashed or stalled ID instruction leaves the scoreboard alone.
  assign w_inc_en = w_issue & id_reg_wr & (id_dest_reg_idx != '0);
  assign w_dec_en = wb_valid_inst & wb_reg_wr & (wb_dest_reg_idx != '0);

  reg_scoreboard u_scoreboard (
    .clk           (clk),
    .rst_n         (rst),
    .i_inc_en      (w_inc_en),
    .i_inc_idx     (id_dest_reg_idx),
    .i_dec_en      (w_dec_en),
    .i_dec_idx     (wb_dest_reg_idx),
    .i_ra_idx      (id_ra_idx),
    .i_rb_idx      (id_rb_idx),
    .o_ra_pending  (w_ra_pending),
    .o_rb_pending  (w_rb_pending),
    .o_any_pending (pending_any)
  );

  // FSM state and MUL occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Pipeline enables from the current state, then issue and next-state decode.
  always_comb begin
    stall         = 1'b0;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;

    case (r_state)
      IDLE: begin
        stall        = w_hazard;
        // A taken branch refills IF/ID from the new PC even while ID is stalled.
        if_id_enable = ~w_hazard | ex_take_branch;
        if_id_flush  = ex_take_branch;
        id_ex_bubble = w_hazard | ex_take_branch;
      end
      MUL_BUSY: begin
        // EX is occupied: freeze everything upstream and let holding win over bubbling ID/EX.
        stall         = 1'b1;
        if_id_enable  = 1'b0;
        ex_hold       = 1'b1;
        ex_mem_bubble = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_issue = id_valid_inst & ~stall & ~ex_take_branch;

    case (r_state)
      IDLE: begin
        if (w_issue && id_is_mul && (MUL_LAT > 1)) begin
          w_state_nxt   = MUL_BUSY;
          w_mul_cnt_nxt = MUL_W'(MUL_LAT - 1);
        end
      end
      MUL_BUSY: begin
        w_mul_cnt_nxt = r_mul_cnt - 1'b1;
        if (r_mul_cnt == MUL_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_mul_cnt_nxt = '0;
      end
    endcase
  end

  // A branch cannot resolve in EX while a multiply owns it.
  a_no_branch_in_mul : assert property (@(posedge clk) disable iff (!rst)
    !((r_state == MUL_BUSY) && ex_take_branch));

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched with a behavioural scoreboard model
module tb_hazard_sched;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid_inst, id_uses_ra, id_uses_rb, id_reg_wr, id_is_mul, ex_take_branch;
  logic [4:0] id_ra_idx, id_rb_idx, id_dest_reg_idx;
  logic       wb_valid_inst, wb_reg_wr;
  logic [4:0] wb_dest_reg_idx;
  logic       stall, if_id_enable, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, pending_any;

  logic       m1_valid, m1_mul;
  logic       m1_stall, m1_ifen, m1_flush, m1_idexb, m1_hold, m1_exmemb, m1_pend;

  hazard_sched #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid_inst(id_valid_inst), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_reg_wr(id_reg_wr),
    .id_dest_reg_idx(id_dest_reg_idx), .id_is_mul(id_is_mul), .ex_take_branch(ex_take_branch),
    .wb_valid_inst(wb_valid_inst), .wb_reg_wr(wb_reg_wr), .wb_dest_reg_idx(wb_dest_reg_idx),
    .stall(stall), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .pending_any(pending_any)
  );

  hazard_sched #(.MUL_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .id_valid_inst(m1_valid), .id_uses_ra(1'b0), .id_uses_rb(1'b0),
    .id_ra_idx(5'd0), .id_rb_idx(5'd0), .id_reg_wr(1'b0),
    .id_dest_reg_idx(5'd0), .id_is_mul(m1_mul), .ex_take_branch(1'b0),
    .wb_valid_inst(1'b0), .wb_reg_wr(1'b0), .wb_dest_reg_idx(5'd0),
    .stall(m1_stall), .if_id_enable(m1_ifen), .if_id_flush(m1_flush),
    .id_ex_bubble(m1_idexb), .ex_hold(m1_hold), .ex_mem_bubble(m1_exmemb),
    .pending_any(m1_pend)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending write count per register and remaining extra EX cycles of a multiply.
  int   m_cnt [32];
  int   m_busy;
  logic e_stall, e_ifen, e_flush, e_idexb, e_hold, e_exmemb, e_pend;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_busy = 0;
  endtask

  task automatic model_eval();
    logic haz;
    haz = id_valid_inst &&
          ((id_uses_ra && id_ra_idx != 0 && m_cnt[id_ra_idx] > 0) ||
           (id_uses_rb && id_rb_idx != 0 && m_cnt[id_rb_idx] > 0));
    if (m_busy > 0) begin
      e_stall = 1; e_ifen = 0; e_flush = 0; e_idexb = 0; e_hold = 1; e_exmemb = 1;
    end else begin
      e_stall = haz; e_ifen = !haz || ex_take_branch; e_flush = ex_take_branch;
      e_idexb = haz || ex_take_branch; e_hold = 0; e_exmemb = 0;
    end
    e_pend = 0;
    for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) e_pend = 1;
  endtask

  // Advance one clock and apply the cycle's issue/retire to the model.
  task automatic tick();
    logic issue;
    model_eval();
    issue = id_valid_inst && !e_stall && !ex_take_branch;
    @(posedge clk);
    if (issue && id_reg_wr && id_dest_reg_idx != 0) m_cnt[id_dest_reg_idx]++;
    if (wb_valid_inst && wb_reg_wr && wb_dest_reg_idx != 0) m_cnt[wb_dest_reg_idx]--;
    if (m_busy > 0) m_busy--;
    else if (issue && id_is_mul && LAT > 1) m_busy = LAT - 1;
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic ua, input int ra, input logic ub, input int rb,
                        input logic wr, input int rd, input logic mul);
    id_valid_inst = v; id_uses_ra = ua; id_ra_idx = 5'(ra); id_uses_rb = ub; id_rb_idx = 5'(rb);
    id_reg_wr = wr; id_dest_reg_idx = 5'(rd); id_is_mul = mul;
  endtask

  task automatic set_wb(input logic v, input logic wr, input int rd);
    wb_valid_inst = v; wb_reg_wr = wr; wb_dest_reg_idx = 5'(rd);
  endtask

  task automatic test_reset();
    logic [6:0] got;
    #1;
    got = {stall, if_id_enable, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, pending_any};
    total++;
    if (got !== 7'b0100000) begin bad++; $display("FAIL reset_outputs got=%b want=0100000", got); end
  endtask

  task automatic test_raw();
    set_id(1, 1, 0, 0, 0, 1, 5, 0); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_cyc0_stall got=%b want=0", stall); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      set_id(1, 1, 5, 1, 1, 1, 6, 0); set_wb(c == 3, 1, 5); #1;
      total++;
      if ({stall, id_ex_bubble} !== 2'b11) begin
        bad++; $display("FAIL raw_stall_cyc%0d got=%b%b want=11", c, stall, id_ex_bubble);
      end
      tick();
    end
    set_wb(0, 0, 0); #1;
    total++;
    if ({stall, id_ex_bubble} !== 2'b00) begin
      bad++; $display("FAIL raw_issue_cyc4 got=%b%b want=00", stall, id_ex_bubble);
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 1, 6); tick();
    set_wb(0, 0, 0); #1;
    total++; if (pending_any !== 1'b0) begin bad++; $display("FAIL raw_drained got=%b want=0", pending_any); end
  endtask

  task automatic test_x0();
    set_id(1, 1, 0, 0, 0, 1, 0, 0); #1;
    total++;
    if ({stall, pending_any} !== 2'b00) begin bad++; $display("FAIL x0_addi got=%b%b want=00", stall, pending_any); end
    tick();
    set_id(1, 1, 0, 1, 0, 1, 1, 0); #1;
    total++;
    if ({stall, pending_any} !== 2'b00) begin bad++; $display("FAIL x0_add got=%b%b want=00", stall, pending_any); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 1, 1); tick();
    set_wb(0, 0, 0);
  endtask

  task automatic test_mul();
    logic [4:0] got;
    set_id(1, 1, 1, 1, 2, 1, 7, 1); #1;
    total++;
    if ({stall, ex_hold} !== 2'b00) begin bad++; $display("FAIL mul_cyc0 got=%b%b want=00", stall, ex_hold); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      set_id(1, 1, 0, 0, 0, 1, 8, 0); #1;
      got = {stall, if_id_enable, id_ex_bubble, ex_hold, ex_mem_bubble};
      total++;
      if (got !== 5'b10011) begin bad++; $display("FAIL mul_busy_cyc%0d got=%b want=10011", c, got); end
      tick();
    end
    #1;
    total++;
    if ({stall, ex_hold, ex_mem_bubble} !== 3'b000) begin
      bad++; $display("FAIL mul_idle_cyc4 got=%b%b%b want=000", stall, ex_hold, ex_mem_bubble);
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 1, 7); tick();
    set_wb(1, 1, 8); tick();
    set_wb(0, 0, 0);
  endtask

  task automatic test_mul_lat1();
    m1_valid = 1; m1_mul = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({m1_hold, m1_stall} !== 2'b00) begin
        bad++; $display("FAIL mul_lat1_cyc%0d got=%b%b want=00", c, m1_hold, m1_stall);
      end
      tick();
    end
    m1_valid = 0; m1_mul = 0;
  endtask

  task automatic test_branch();
    logic [3:0] got;
    set_id(1, 1, 0, 0, 0, 1, 5, 0); tick();
    set_id(1, 1, 5, 0, 0, 1, 6, 0); ex_take_branch = 1; #1;
    got = {if_id_flush, id_ex_bubble, if_id_enable, stall};
    total++;
    if (got !== 4'b1111) begin bad++; $display("FAIL branch_flush got=%b want=1111", got); end
    tick();
    ex_take_branch = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 1, 5); #1;
    total++; if (pending_any !== 1'b1) begin bad++; $display("FAIL branch_x5_pending got=%b want=1", pending_any); end
    tick();
    set_wb(0, 0, 0); #1;
    total++; if (pending_any !== 1'b0) begin bad++; $display("FAIL branch_no_cnt got=%b want=0", pending_any); end
  endtask

  task automatic test_same_cycle();
    set_id(1, 1, 0, 0, 0, 1, 9, 0); tick();
    set_wb(1, 1, 9); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (pending_any !== 1'b1) begin bad++; $display("FAIL same_cycle_kept got=%b want=1", pending_any); end
    tick();
    set_wb(0, 0, 0); #1;
    total++; if (pending_any !== 1'b0) begin bad++; $display("FAIL same_cycle_cnt1 got=%b want=0", pending_any); end
  endtask

  task automatic test_back_to_back();
    set_id(1, 1, 0, 0, 0, 1, 9, 0);
    for (int c = 0; c < 3; c++) tick();
    for (int c = 3; c <= 5; c++) begin
      set_id(1, 1, 9, 0, 0, 0, 0, 0); set_wb(1, 1, 9); #1;
      total++;
      if ({stall, pending_any} !== 2'b11) begin
        bad++; $display("FAIL b2b_cyc%0d got=%b%b want=11", c, stall, pending_any);
      end
      tick();
    end
    set_wb(0, 0, 0); #1;
    total++;
    if ({stall, pending_any} !== 2'b00) begin bad++; $display("FAIL b2b_cyc6 got=%b%b want=00", stall, pending_any); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    set_id(1, 1, 0, 0, 0, 1, 5, 0); tick(); tick();
    set_id(1, 1, 1, 1, 2, 1, 7, 1); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    total++;
    if ({ex_hold, pending_any} !== 2'b11) begin bad++; $display("FAIL pre_reset got=%b%b want=11", ex_hold, pending_any); end
    rst = 0; #1;
    model_reset();
    total++;
    if ({stall, pending_any, ex_hold} !== 3'b000) begin
      bad++; $display("FAIL reset_mid_mul got=%b%b%b want=000", stall, pending_any, ex_hold);
    end
    @(posedge clk); @(negedge clk);
    rst = 1; #1;
    total++;
    if ({stall, pending_any, ex_hold, if_id_enable} !== 4'b0001) begin
      bad++; $display("FAIL after_reset got=%b%b%b%b want=0001", stall, pending_any, ex_hold, if_id_enable);
    end
  endtask

  task automatic test_random();
    logic [6:0] got, exp;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 7);
      set_id($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7), 1'($urandom),
             $urandom_range(0, 7), 1'($urandom), r, $urandom_range(0, 7) == 0);
      if (m_cnt[r] >= 3) id_reg_wr = 0;
      ex_take_branch = (m_busy == 0) && ($urandom_range(0, 9) == 0);
      r = $urandom_range(1, 7);
      if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) set_wb(1, 1, r);
      else set_wb(1'($urandom), 1'($urandom), 0);
      #1;
      model_eval();
      got = {stall, if_id_enable, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, pending_any};
      exp = {e_stall, e_ifen, e_flush, e_idexb, e_hold, e_exmemb, e_pend};
      total++;
      if (got !== exp) begin bad++; $display("FAIL random_cyc%0d got=%b want=%b", n, got, exp); end
      tick();
    end
    ex_take_branch = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(0, 0, 0);
  endtask

  initial begin
    rst = 0;
    m1_valid = 0; m1_mul = 0; ex_take_branch = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0); set_wb(0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1;
    @(negedge clk);
    test_raw();
    test_x0();
    test_mul();
    test_mul_lat1();
    test_branch();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
